// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Sequences trap entry and return for the newt integer pipeline. Nine
//   one-cycle trap pulses are latched into pending bits while idle; the
//   level-sensitive IOINT joins them when ioEn is set. The highest-priority
//   source (lowest reason code) is serviced by walking the pipeline through
//   flush, save-PC and vector fetch. Further traps are then masked until
//   the handler retires rett. A trap pulse inside the handler is fatal and
//   parks the block in HALT until reset.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   GStrap .. instrpagefINT : one-cycle trap pulses (reason codes 0..8)
//   IOINT             : level I/O interrupt request (reason code 9)
//   curPC             : PC of the faulting / interrupted instruction
//   vecBase           : trap table base, bits [7:0] ignored
//   flushAck          : pipeline flush complete
//   vecReady          : fetch unit accepts vecAddr
//   rett              : handler return retired (pulse)
//   flushReq          : flush request (asserted in FLUSH)
//   savePC            : one-cycle strobe in SAVE; epc captures curPC
//   epc               : saved exception PC
//   vecValid, vecAddr : handler address offer (asserted in VECTOR)
//   trapReason        : reason code of the trap being serviced
//   inHandler         : handler active
//   doubleFault       : sticky fatal error
//   dbgState          : current FSM state encoding, for observation only
//
// Handshakes: flushReq stays high until flushAck is sampled high, and
// vecValid stays high with vecAddr frozen until vecReady is sampled high.
// The transfer completes on the rising edge where both sides are high.
// Neither request ever drops before that edge, except on reset.
//
// PC_W must be at least 12 so that the vector has room for
// {base, reason, 4'b0000}.

module trap_sequencer #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            GStrap,
   input  logic            trapinstr,
   input  logic            datapagefINT,
   input  logic            winunderflow,
   input  logic            winoverflow,
   input  logic            SWI,
   input  logic            intTAGtrap,
   input  logic            illegalopc,
   input  logic            instrpagefINT,
   input  logic            IOINT,
   input  logic [PC_W-1:0] curPC,
   input  logic [PC_W-1:0] vecBase,
   input  logic            flushAck,
   input  logic            vecReady,
   input  logic            rett,
   output logic            flushReq,
   output logic            savePC,
   output logic [PC_W-1:0] epc,
   output logic            vecValid,
   output logic [PC_W-1:0] vecAddr,
   output logic [3:0]      trapReason,
   output logic            inHandler,
   output logic            doubleFault,
   output logic [2:0]      dbgState
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FLUSH   = 3'd1,
      SAVE    = 3'd2,
      VECTOR  = 3'd3,
      HANDLER = 3'd4,
      HALT    = 3'd5
   } state_t;

   state_t     state;
   logic [8:0] pending;
   logic       ioen;

   // Pulse sources packed so that bit index equals reason code.
   logic [8:0] src;
   assign src = {instrpagefINT, GStrap, trapinstr, datapagefINT,
                 winunderflow, winoverflow, SWI, intTAGtrap, illegalopc};

   // The low byte of vecBase is replaced by the reason field.
   logic unused_vecbase;
   assign unused_vecbase = ^vecBase[7:0];

   // Priority pick: the lowest set pending index wins, and IOINT only
   // wins when no pending bit is set. win_onehot is the pending bit to
   // clear on entry; it stays zero when IOINT wins, because IOINT is not
   // latched.
   logic [3:0] win_code;
   logic [8:0] win_onehot;
   logic       any_req;

   always_comb begin
      win_code   = 4'd9;
      win_onehot = '0;
      for (int i = 8; i >= 0; i--) begin
         if (pending[i]) begin
            win_code      = 4'(i);
            win_onehot    = '0;
            win_onehot[i] = 1'b1;
         end
      end
      any_req = (|pending) | (IOINT & ioen);
   end

   // All handshake outputs are assigned on the transition into the state
   // that owns them. This keeps them registered and equal to a decode of
   // the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pending     <= '0;
         ioen        <= 1'b1;
         trapReason  <= '0;
         epc         <= '0;
         vecAddr     <= '0;
         flushReq    <= 1'b0;
         savePC      <= 1'b0;
         vecValid    <= 1'b0;
         inHandler   <= 1'b0;
         doubleFault <= 1'b0;
      end else begin
         savePC <= 1'b0;
         case (state)
            IDLE: begin
               // New pulses are latched even on the entry edge; only the
               // winning bit is consumed, so losers stay pending.
               pending <= (pending & ~win_onehot) | src;
               if (any_req) begin
                  trapReason <= win_code;
                  ioen       <= 1'b0;
                  flushReq   <= 1'b1;
                  state      <= FLUSH;
               end
            end

            // Pulses seen from here to VECTOR come from instructions
            // being flushed and are deliberately dropped.
            FLUSH: begin
               if (flushAck) begin
                  flushReq <= 1'b0;
                  savePC   <= 1'b1;
                  state    <= SAVE;
               end
            end

            SAVE: begin
               epc      <= curPC;
               // The vector is frozen here, so later vecBase changes
               // cannot disturb an offer the fetch unit is looking at.
               vecAddr  <= {vecBase[PC_W-1:8], trapReason, 4'b0000};
               vecValid <= 1'b1;
               state    <= VECTOR;
            end

            VECTOR: begin
               if (vecReady) begin
                  vecValid  <= 1'b0;
                  inHandler <= 1'b1;
                  state     <= HANDLER;
               end
            end

            HANDLER: begin
               // A trap inside the handler is fatal even when rett
               // retires on the same cycle.
               if (|src) begin
                  inHandler   <= 1'b0;
                  doubleFault <= 1'b1;
                  state       <= HALT;
               end else if (rett) begin
                  inHandler <= 1'b0;
                  ioen      <= 1'b1;
                  state     <= IDLE;
               end
            end

            HALT: begin
               // Only reset leaves HALT.
            end

            default: begin
               state <= HALT;
            end
         endcase
      end
   end

   assign dbgState = state;

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer. Directed scenarios drive trap sources and
// handshakes. Every expected handler entry is pushed to a scoreboard queue,
// and a monitor pops it when the vector handshake completes.
module tb_trap_sequencer;

  localparam int PC_W = 32;
  localparam int W    = 4 + 2 * PC_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic [8:0]      src = '0;
  logic            ioint = 1'b0;
  logic [PC_W-1:0] cur_pc = '0;
  logic [PC_W-1:0] vec_base = '0;
  logic            flush_ack = 1'b1;
  logic            vec_ready = 1'b1;
  logic            rett = 1'b0;

  // dut outputs
  logic            flush_req, save_pc, vec_valid, in_handler, double_fault;
  logic [PC_W-1:0] epc, vec_addr;
  logic [3:0]      trap_reason;
  logic [2:0]      dbg_state;

  trap_sequencer #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .GStrap        (src[7]),
    .trapinstr     (src[6]),
    .datapagefINT  (src[5]),
    .winunderflow  (src[4]),
    .winoverflow   (src[3]),
    .SWI           (src[2]),
    .intTAGtrap    (src[1]),
    .illegalopc    (src[0]),
    .instrpagefINT (src[8]),
    .IOINT         (ioint),
    .curPC         (cur_pc),
    .vecBase       (vec_base),
    .flushAck      (flush_ack),
    .vecReady      (vec_ready),
    .rett          (rett),
    .flushReq      (flush_req),
    .savePC        (save_pc),
    .epc           (epc),
    .vecValid      (vec_valid),
    .vecAddr       (vec_addr),
    .trapReason    (trap_reason),
    .inHandler     (in_handler),
    .doubleFault   (double_fault),
    .dbgState      (dbg_state)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PC_W-1:0] exp_vec(input logic [PC_W-1:0] base, input int code);
    logic [3:0] c;
    c = 4'(code);
    return {base[PC_W-1:8], c, 4'b0000};
  endfunction

  task automatic push_entry(input int code);
    exp_q.push_back({4'(code), exp_vec(vec_base, code), cur_pc});
  endtask

  // Monitor: one expected entry per completed vector handshake.
  always @(negedge clk) begin
    if (rst_n && vec_valid && vec_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_entry", 64'(exp_q.size()), 64'd1);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_reason", 64'(trap_reason), 64'(sb_e[W-1 -: 4]));
        check("sb_vecaddr", 64'(vec_addr), 64'(sb_e[2*PC_W-1 -: PC_W]));
        check("sb_epc", 64'(epc), 64'(sb_e[PC_W-1:0]));
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [8:0] bits);
    src = bits;
    tick(1);
    src = '0;
  endtask

  task automatic do_rett();
    rett = 1'b1;
    tick(1);
    rett = 1'b0;
  endtask

  task automatic wait_handler(input string tag);
    int n;
    n = 0;
    while (in_handler !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, 64'(in_handler), 64'd1);
  endtask

  task automatic wait_vec(input string tag);
    int n;
    n = 0;
    while (vec_valid !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, 64'(vec_valid), 64'd1);
  endtask

  initial begin
    int n;
    logic [PC_W-1:0] held;

    // reset
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("rst_flushreq", 64'(flush_req), 64'd0);
    check("rst_savepc", 64'(save_pc), 64'd0);
    check("rst_vecvalid", 64'(vec_valid), 64'd0);
    check("rst_inhandler", 64'(in_handler), 64'd0);
    check("rst_doublefault", 64'(double_fault), 64'd0);
    check("rst_reason", 64'(trap_reason), 64'd0);
    check("rst_epc", 64'(epc), 64'd0);

    // single trap, minimum latency
    cur_pc = 32'h0000_1234;
    vec_base = 32'h0000_A0FF;
    push_entry(4);
    pulse(9'h010);
    check("t1_no_flush_yet", 64'(flush_req), 64'd0);
    tick(1);
    check("t1_flushreq", 64'(flush_req), 64'd1);
    tick(1);
    check("t1_savepc", 64'(save_pc), 64'd1);
    check("t1_flush_drop", 64'(flush_req), 64'd0);
    tick(1);
    check("t1_savepc_once", 64'(save_pc), 64'd0);
    check("t1_vecvalid", 64'(vec_valid), 64'd1);
    check("t1_vecaddr", 64'(vec_addr), 64'h0000_A040);
    check("t1_reason", 64'(trap_reason), 64'd4);
    check("t1_epc", 64'(epc), 64'h0000_1234);
    tick(1);
    check("t1_inhandler", 64'(in_handler), 64'd1);
    check("t1_vec_drop", 64'(vec_valid), 64'd0);
    do_rett();
    check("t1_rett_idle", 64'(in_handler), 64'd0);
    tick(2);
    check("t1_no_reentry", 64'(flush_req), 64'd0);

    // priority: SWI beats GStrap, GStrap is serviced afterwards
    cur_pc = 32'h0000_2000;
    push_entry(2);
    push_entry(7);
    pulse(9'h084);
    wait_handler("t2_wait1");
    check("t2_reason1", 64'(trap_reason), 64'd2);
    do_rett();
    check("t2_b2b_idle", 64'(flush_req), 64'd0);
    tick(1);
    check("t2_b2b_flush", 64'(flush_req), 64'd1);
    wait_handler("t2_wait2");
    check("t2_reason2", 64'(trap_reason), 64'd7);
    do_rett();
    tick(3);
    check("t2_drained", 64'(flush_req), 64'd0);

    // IOINT masking and re-entry
    cur_pc = 32'h0000_3300;
    push_entry(9);
    ioint = 1'b1;
    tick(1);
    check("t3_io_flush", 64'(flush_req), 64'd1);
    wait_handler("t3_wait1");
    check("t3_reason", 64'(trap_reason), 64'd9);
    tick(5);
    check("t3_masked_inh", 64'(in_handler), 64'd1);
    check("t3_masked_flush", 64'(flush_req), 64'd0);
    push_entry(9);
    do_rett();
    check("t3_rett_idle", 64'(flush_req), 64'd0);
    tick(1);
    check("t3_reentry", 64'(flush_req), 64'd1);
    ioint = 1'b0;
    wait_handler("t3_wait2");
    do_rett();
    tick(3);
    check("t3_quiet", 64'(flush_req), 64'd0);

    // handshake stalls
    cur_pc = 32'h0000_4444;
    flush_ack = 1'b0;
    vec_ready = 1'b0;
    push_entry(0);
    pulse(9'h001);
    tick(1);
    n = 0;
    while (flush_req === 1'b1 && n < 20) begin
      n++;
      if (n == 6) flush_ack = 1'b1;
      tick(1);
    end
    check("t4_flush_len", 64'(n), 64'd6);
    check("t4_savepc", 64'(save_pc), 64'd1);
    tick(1);
    held = exp_vec(vec_base, 0);
    vec_base = 32'h0000_B0FF;
    n = 0;
    while (vec_valid === 1'b1 && n < 20) begin
      n++;
      check("t4_vec_stable", 64'(vec_addr), 64'(held));
      if (n == 4) vec_ready = 1'b1;
      tick(1);
    end
    check("t4_vec_len", 64'(n), 64'd4);
    check("t4_inhandler", 64'(in_handler), 64'd1);
    vec_base = 32'h0000_A0FF;
    do_rett();

    // double fault
    cur_pc = 32'h0000_5550;
    push_entry(3);
    pulse(9'h008);
    wait_handler("t5_wait");
    src = 9'h001;
    rett = 1'b1;
    tick(1);
    src = '0;
    rett = 1'b0;
    check("t5_doublefault", 64'(double_fault), 64'd1);
    check("t5_inh_drop", 64'(in_handler), 64'd0);
    do_rett();
    pulse(9'h020);
    tick(4);
    check("t5_sticky", 64'(double_fault), 64'd1);
    check("t5_halt_flush", 64'(flush_req), 64'd0);
    check("t5_halt_vec", 64'(vec_valid), 64'd0);
    check("t5_halt_inh", 64'(in_handler), 64'd0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t5_rst_df", 64'(double_fault), 64'd0);
    check("t5_rst_epc", 64'(epc), 64'd0);
    check("t5_rst_reason", 64'(trap_reason), 64'd0);
    check("t5_rst_inh", 64'(in_handler), 64'd0);
    tick(3);
    check("t5_rst_quiet", 64'(flush_req), 64'd0);

    // discard during FLUSH
    cur_pc = 32'h0000_6600;
    flush_ack = 1'b0;
    push_entry(6);
    pulse(9'h040);
    tick(1);
    check("t6_flushing", 64'(flush_req), 64'd1);
    pulse(9'h020);
    flush_ack = 1'b1;
    wait_handler("t6_wait");
    check("t6_reason", 64'(trap_reason), 64'd6);
    do_rett();
    tick(4);
    check("t6_discarded", 64'(flush_req), 64'd0);

    // reset mid-handshake clears retained pending
    vec_ready = 1'b0;
    pulse(9'h102);
    wait_vec("t7_wait_vec");
    check("t7_reason", 64'(trap_reason), 64'd1);
    rst_n = 1'b0;
    tick(1);
    check("t7_rst_vec", 64'(vec_valid), 64'd0);
    rst_n = 1'b1;
    vec_ready = 1'b1;
    tick(5);
    check("t7_pending_clr", 64'(flush_req), 64'd0);
    check("t7_state_idle", 64'(dbg_state), 64'd0);

    // final report
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequences trap entry and return for the newt integer pipeline. It latches trap and interrupt sources, picks the highest-priority one using the TRAPreason encoding, and drives the flush / save-PC / vector-fetch handshake with the pipeline. It then masks further traps until the handler executes `rett`. It sits between the per-stage fault detectors and the fetch unit.

## Interface
- `PC_W`, default 32: program-counter and vector-address width; must be ≥ 12.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `GStrap`, `trapinstr`, `datapagefINT`, `winunderflow`, `winoverflow`, `SWI`, `intTAGtrap`, `illegalopc`, `instrpagefINT` input, 1 bit each: one-cycle synchronous trap pulses.
- `IOINT` input, 1 bit: level-sensitive I/O interrupt request.
- `curPC` input, `PC_W` bits: PC of the faulting or interrupted instruction.
- `vecBase` input, `PC_W` bits: trap table base; bits [7:0] are ignored.
- `flushAck` input, 1 bit: pipeline has finished flushing.
- `vecReady` input, 1 bit: fetch unit accepts the vector address.
- `rett` input, 1 bit: one-cycle pulse when the handler's return retires.
- `flushReq` output, 1 bit: request a pipeline flush.
- `savePC` output, 1 bit: one-cycle strobe; `epc` is updated on this cycle.
- `epc` output, `PC_W` bits: saved exception PC.
- `vecValid` output, 1 bit: vector address valid.
- `vecAddr` output, `PC_W` bits: handler address.
- `trapReason` output, 4 bits: latched reason code.
- `inHandler` output, 1 bit: trap handler is active.
- `doubleFault` output, 1 bit: sticky fatal-error flag.

## Operation
- **Reason codes, highest priority first:**
  - `illegalopc`=0, `intTAGtrap`=1, `SWI`=2, `winoverflow`=3.
  - `winunderflow`=4, `datapagefINT`=5, `trapinstr`=6, `GStrap`=7.
  - `instrpagefINT`=8, `IOINT`=9.
- **Pending bits:**
  - There are 9 pending bits, one per pulse source.
  - A pending bit is set only when its source pulses while the state is IDLE.
  - Pulses arriving in FLUSH, SAVE or VECTOR are discarded, because they belong to flushed instructions.
- **IOINT:** not latched. It participates only while `ioEn`=1. `ioEn` resets to 1, is cleared on trap entry, and is set again on `rett`.
- **States:** IDLE, FLUSH, SAVE, VECTOR, HANDLER, HALT.
  - **IDLE:** if any pending bit is set, or `IOINT`&`ioEn`:
    - latch the winning code into `trapReason`;
    - clear only that pending bit;
    - clear `ioEn`;
    - go to FLUSH.
    Losing pending bits are retained.
  - **FLUSH:** `flushReq`=1. Go to SAVE on the first cycle `flushAck`=1.
  - **SAVE:** `savePC`=1 for exactly one cycle; `epc` <= `curPC`. Go to VECTOR.
  - **VECTOR:** `vecValid`=1 and `vecAddr`={`vecBase`[PC_W-1:8], `trapReason`, 4'b0000}. On `vecValid`&`vecReady`, go to HANDLER. `vecAddr` stays stable while waiting.
  - **HANDLER:** `inHandler`=1.
    - `rett` -> IDLE and `ioEn`<=1.
    - Any of the 9 pulse sources asserted -> HALT. This takes priority over a simultaneous `rett`.
  - **HALT:** `doubleFault`=1 and all other handshake outputs 0. Only reset exits HALT.
- `rett` outside HANDLER is ignored.
- Pending bits left from earlier are serviced when the state returns to IDLE, in priority order, one trap per entry.

## Timing
- **Reset values:** state IDLE; pending=0; `ioEn`=1; `trapReason`=0; `epc`=0. Outputs `flushReq`, `savePC`, `vecValid`, `inHandler` and `doubleFault` are all 0.
- **Reset priority:** reset wins in every state, including mid-handshake. `flushReq` and `vecValid` drop on the cycle after `rst_n` is sampled low.
- **Entry latency:**
  - A source pulse at edge N sets its pending bit at N+1.
  - IDLE evaluates at N+1, and FLUSH (`flushReq`=1) is entered at N+2.
  - For `IOINT`, the level sampled at N gives FLUSH at N+1.
- **Minimum sequence:** with `flushAck` and `vecReady` tied high, FLUSH, SAVE and VECTOR each last 1 cycle. HANDLER is then entered 3 cycles after FLUSH starts.
- **Output encoding:** all handshake outputs are registered Moore outputs of the state.
- **Output stability:** `trapReason` changes only on IDLE->FLUSH. `epc` changes only in SAVE.
- **Back-to-back traps:** `rett` at edge M gives IDLE at M+1. A retained pending bit gives FLUSH at M+2.

## Test plan
- **Single trap:** `winunderflow` pulse with acks tied high -> `flushReq` 2 cycles later, then `savePC` with `epc`=`curPC`=0x00001234. Expect `vecAddr`=0x0000A040 for `vecBase`=0x0000A0FF and `trapReason`=4, then `inHandler`=1.
- **Priority:** `SWI` and `GStrap` pulse in the same cycle -> first entry `trapReason`=2. After `rett`, a second entry with `trapReason`=7 and no new stimulus.
- **IOINT masking:** `IOINT` held high -> entry with `trapReason`=9. No re-entry while in HANDLER. After `rett`, re-entry begins 2 cycles later if `IOINT` is still high.
- **Handshake stalls:** `flushAck` low for 5 cycles -> `flushReq` held for 6 cycles. `vecReady` low for 3 cycles -> `vecValid`/`vecAddr` held stable for 4 cycles.
- **Double fault:** `illegalopc` pulse in HANDLER coincident with `rett` -> HALT with `doubleFault`=1. A later `rett` or trap pulse causes no change. `rst_n`=0 for 1 cycle returns every output to 0.
- **Discard and reset mid-handshake:** `datapagefINT` pulse during FLUSH -> not serviced after `rett`. `rst_n` low during VECTOR -> `vecValid`=0 on the next cycle and pending is cleared.
